// File: rtl/uart_msg_framer.sv
// uart_msg_framer: groups received UART bytes into DELIM-terminated messages and releases only
// complete messages from a store-and-forward byte FIFO. Define UART_MSG_TIMEOUT_EN for idle auto-close.
module uart_msg_framer #(
  parameter int         DEPTH          = 64,
  parameter logic [7:0] DELIM          = 8'h0A,
  parameter int         MAX_MSG_LEN    = 32,
  parameter int         TIMEOUT_CYCLES = 1041700
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_i,
  input  logic                   clear_err_i,
  output logic [7:0]             m_data_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [$clog2(DEPTH):0] msg_pending_o,
  output logic                   overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {ACCEPT, DISCARD} state_t;

  state_t        state_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, start_q, len_q, pending_q, pending_d;
  logic          overflow_q;
  logic [8:0]    mem_q [DEPTH];

  logic [PW-1:0] fill;
  logic          full, is_delim, pop, pop_last, tmo_fire;
  logic          wr_en, commit, drop;
  logic [8:0]    wr_word;

  assign fill          = wr_ptr_q - rd_ptr_q;
  assign full          = (fill == PW'(DEPTH));
  assign is_delim      = (byte_i == DELIM);
  assign m_valid_o     = (pending_q != '0);
  assign m_data_o      = mem_q[rd_ptr_q[AW-1:0]][7:0];
  assign m_last_o      = mem_q[rd_ptr_q[AW-1:0]][8];
  assign msg_pending_o = pending_q;
  assign overflow_o    = overflow_q;
  assign pop           = m_valid_o && m_ready_i;
  assign pop_last      = pop && m_last_o;

`ifdef UART_MSG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] idle_q;

  // Down-counter reloaded by every byte; holds at zero once the line has gone idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 idle_q <= TW'(TIMEOUT_CYCLES - 1);
    else if (byte_valid_i)      idle_q <= TW'(TIMEOUT_CYCLES - 1);
    else if (idle_q != '0)      idle_q <= idle_q - TW'(1);
  end
  assign tmo_fire = !byte_valid_i && (idle_q == '0);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_fire   = 1'b0;
`endif

  always_comb begin
    wr_en   = 1'b0;
    commit  = 1'b0;
    drop    = 1'b0;
    wr_word = {is_delim, byte_i};
    if (state_q == ACCEPT) begin
      if (byte_valid_i) begin
        if (full || (len_q == PW'(MAX_MSG_LEN - 1) && !is_delim)) begin
          drop = 1'b1;
        end else begin
          wr_en  = 1'b1;
          commit = is_delim;
        end
      end else if (tmo_fire && len_q != '0) begin
        if (full) begin
          drop = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_word = {1'b1, DELIM};
          commit  = 1'b1;
        end
      end
    end
  end

  assign pending_d = pending_q + PW'(commit) - PW'(pop_last);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCEPT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      start_q    <= '0;
      len_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      // A drop rewinds to the start of the open message, so its stored bytes are reclaimed.
      if (drop) begin
        wr_ptr_q <= start_q;
        len_q    <= '0;
        state_q  <= byte_valid_i ? DISCARD : ACCEPT;
      end else if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        if (commit) begin
          start_q <= wr_ptr_q + PW'(1);
          len_q   <= '0;
        end else begin
          len_q   <= len_q + PW'(1);
        end
      end

      if (state_q == DISCARD && ((byte_valid_i && is_delim) || tmo_fire)) state_q <= ACCEPT;

      if (drop)             overflow_q <= 1'b1;
      else if (clear_err_i) overflow_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_msg_framer.sv
// Bench for uart_msg_framer: directed scenarios then random traffic against a queue-based message model.
module tb_uart_msg_framer;
  localparam int         DEPTH = 64;
  localparam int         MAXL  = 32;
  localparam int         TMO   = 100;
  localparam logic [7:0] DELIM = 8'h0A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       byte_valid_i = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       clear_err_i = 1'b0;
  logic       m_ready_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_last_o, m_valid_o, overflow_o;
  logic [6:0] msg_pending_o;

  int checks = 0;
  int errors = 0;

  logic [8:0] stored[$];
  logic [8:0] cur[$];
  bit         discard;
  bit         ovf;
  int         pend;
`ifdef UART_MSG_TIMEOUT_EN
  int         idle;
`endif

  uart_msg_framer #(.DEPTH(DEPTH), .DELIM(DELIM), .MAX_MSG_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .byte_valid_i(byte_valid_i), .byte_i(byte_i),
    .clear_err_i(clear_err_i), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .msg_pending_o(msg_pending_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("m_valid", 32'(m_valid_o), 32'(pend != 0));
    if (pend != 0) begin
      chk("m_data", 32'(m_data_o), 32'(stored[0][7:0]));
      chk("m_last", 32'(m_last_o), 32'(stored[0][8]));
    end
    chk("pending", 32'(msg_pending_o), 32'(pend));
    chk("overflow", 32'(overflow_o), 32'(ovf));
  endtask

  task automatic model_reset();
    stored.delete();
    cur.delete();
    discard = 0;
    ovf = 0;
    pend = 0;
`ifdef UART_MSG_TIMEOUT_EN
    idle = 0;
`endif
  endtask

  task automatic commit_cur();
    foreach (cur[i]) stored.push_back(cur[i]);
    cur.delete();
    pend++;
  endtask

  // One clock edge of the framer, expressed as message-level rules on the model queues.
  task automatic model_edge(input logic bv, input logic [7:0] b, input logic rdy, input logic clr);
    int pre_fill = stored.size() + cur.size();
    bit tmo = 0;
    logic [8:0] h;
`ifdef UART_MSG_TIMEOUT_EN
    if (bv) idle = 0;
    else begin
      tmo = (idle >= TMO - 1);
      if (idle < TMO - 1) idle++;
    end
`endif
    if (pend != 0 && rdy) begin
      h = stored.pop_front();
      if (h[8]) pend--;
    end
    if (clr) ovf = 0;
    if (bv) begin
      if (discard) begin
        if (b == DELIM) discard = 0;
      end else if (pre_fill == DEPTH || (cur.size() == MAXL - 1 && b != DELIM)) begin
        cur.delete();
        ovf = 1;
        discard = 1;
      end else begin
        cur.push_back({b == DELIM, b});
        if (b == DELIM) commit_cur();
      end
    end else if (tmo) begin
      if (discard) discard = 0;
      else if (cur.size() != 0) begin
        if (pre_fill == DEPTH) begin
          cur.delete();
          ovf = 1;
        end else begin
          cur.push_back({1'b1, DELIM});
          commit_cur();
        end
      end
    end
  endtask

  task automatic step(input logic bv, input logic [7:0] b, input logic rdy, input logic clr);
    check_outputs();
    byte_valid_i = bv;
    byte_i       = b;
    m_ready_i    = rdy;
    clear_err_i  = clr;
    model_edge(bv, b, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    byte_valid_i = 1'b0;
    m_ready_i = 1'b0;
    clear_err_i = 1'b0;
    #2;
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_pending", 32'(msg_pending_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rdy_pct;
    #1;
    do_reset();

    // Short message with consumer always ready.
    step(1, "H", 1, 0);
    step(1, "I", 1, 0);
    step(1, DELIM, 1, 0);
    chk("t1_valid", 32'(m_valid_o), 1);
    chk("t1_data", 32'(m_data_o), 32'h48);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    chk("t1_pending_end", 32'(msg_pending_o), 0);

    // Three buffered 4-byte messages, then drain.
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 3; k++) step(1, 8'(8'h31 + m * 3 + k), 0, 0);
      step(1, DELIM, 0, 0);
    end
    chk("t2_pending", 32'(msg_pending_o), 3);
    for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0);
    chk("t2_pending_end", 32'(msg_pending_o), 0);

    // Oversized message is dropped; bytes up to the next DELIM are ignored.
    for (int i = 0; i < 40; i++) step(1, 8'(8'h61 + i % 26), 0, 0);
    step(1, "A", 0, 0);
    step(1, DELIM, 0, 0);
    chk("t3_overflow", 32'(overflow_o), 1);
    chk("t3_pending", 32'(msg_pending_o), 0);
    step(1, "B", 0, 0);
    step(1, DELIM, 0, 0);
    chk("t3_pending_b", 32'(msg_pending_o), 1);
    chk("t3_data_b", 32'(m_data_o), 32'h42);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0);

    // Fill to capacity; the partial that hits full is dropped, complete messages intact.
    step(0, 8'h00, 0, 1);
    chk("t4_cleared", 32'(overflow_o), 0);
    for (int m = 0; m < 15; m++) begin
      for (int k = 0; k < 3; k++) step(1, 8'(8'h61 + k), 0, 0);
      step(1, DELIM, 0, 0);
    end
    for (int k = 0; k < 5; k++) step(1, 8'(8'h76 + k), 0, 0);
    chk("t4_overflow", 32'(overflow_o), 1);
    chk("t4_pending", 32'(msg_pending_o), 15);
    step(1, DELIM, 0, 0);
    chk("t4_pending_after_delim", 32'(msg_pending_o), 15);
    for (int i = 0; i < 60; i++) step(0, 8'h00, 1, 0);
    chk("t4_pending_end", 32'(msg_pending_o), 0);

    // Last byte popped in the same cycle another message commits.
    step(1, "Z", 0, 0);
    step(1, DELIM, 0, 0);
    step(1, "Q", 1, 0);
    step(1, DELIM, 1, 0);
    chk("t5_pending", 32'(msg_pending_o), 1);
    chk("t5_data", 32'(m_data_o), 32'h51);
    step(0, 8'h00, 0, 1);
    chk("t5_cleared", 32'(overflow_o), 0);
    for (int i = 0; i < 2; i++) step(0, 8'h00, 1, 0);

    // Random traffic with varying consumer throughput.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] b;
      if (i % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 0;
          1:       rdy_pct = 30;
          default: rdy_pct = 90;
        endcase
      end
      b = ($urandom_range(0, 7) == 0) ? DELIM : 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 99) < rdy_pct),
           1'($urandom_range(0, 63) == 0));
    end

    // Idle after a lone byte: auto-closes only when the timeout is built in.
    do_reset();
    step(1, "X", 0, 0);
    for (int i = 0; i < TMO; i++) step(0, 8'h00, 0, 0);
`ifdef UART_MSG_TIMEOUT_EN
    chk("t6_pending", 32'(msg_pending_o), 1);
    chk("t6_data", 32'(m_data_o), 32'h58);
`else
    chk("t6_pending", 32'(msg_pending_o), 0);
`endif
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);

    // Reset in the middle of a message.
    step(1, "P", 0, 0);
    step(1, DELIM, 0, 0);
    step(1, "R", 0, 0);
    do_reset();
    step(0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
